lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit answering the decoder's memory controls (rd_en, wr_en, mem_acc_mode).
//  Sits between ALU result/rs2 and the writeback MUX. Converts one load/store into a single
//  word-aligned bus transaction (req/ack) with byte enables, sign/zero-extends load data,
//  and stalls the core until the transaction completes, errors or times out.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles awaiting bus_ack before abort (>=1)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  rd_en          in   1   load request from decoder
//  wr_en          in   1   store request from decoder
//  mem_acc_mode   in   3   000 B, 001 H, 010 W, 011 BU, 100 HU, others illegal
//  addr           in   32  byte address (ALU result)
//  wdata          in   32  store data (rs2)
//  rdata          out  32  extended load data to writeback MUX
//  stall          out  1   freeze PC/pipeline (combinational)
//  err            out  1   1-cycle pulse: misaligned, illegal mode or bus timeout
//  bus_req        out  1   bus request, held until ack or abort
//  bus_we         out  1   1 = write
//  bus_addr       out  32  {addr[31:2],2'b00}
//  bus_be         out  4   byte enables
//  bus_wdata      out  32  lane-replicated store data
//  bus_ack        in   1   bus completes transaction this cycle
//  bus_rdata      in   32  read word, valid with bus_ack
// BEHAVIOUR
//  Reset: state IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, err, timer = 0.
//  Reset mid-BUSY drops bus_req immediately; the bus must tolerate abandoned transactions.
//  req = rd_en|wr_en. Illegal if: rd_en&wr_en; mode 101/110/111; wr_en with mode 011/100;
//   H/HU with addr[0]=1; W with addr[1:0]!=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: legal req -> stall=1 this cycle; register bus_* fields; bus_req=1; go BUSY.
//         illegal req -> no bus access, err=1 next cycle (in IDLE), stall=0, rdata unchanged.
//   BUSY: stall=1; bus_* held stable. bus_ack -> capture load result to rdata, bus_req=0, go DONE.
//         no ack at timer==TIMEOUT_CYCLES-1 -> bus_req=0, rdata=0 if load, err=1 in DONE.
//         ack in the timeout cycle wins (normal completion). timer cleared on BUSY entry.
//   DONE: stall=0 (core advances at this edge); inputs ignored; unconditionally -> IDLE.
//  Latency: stall high from request cycle through ack cycle; min 2 stall cycles.
//  Back-to-back ops: next request sampled in IDLE the cycle after DONE.
//  Byte enables/data: B: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}};
//   H: be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}; W: be=4'b1111, wdata as is.
//   Loads drive be per same rule; bus_we=wr_en.
//  Load extract: lane = bus_rdata >> (8*addr[1:0]); B/H sign-extend bit 7/15; BU/HU zero-extend.
//  rdata holds last completed load value until next load completes; stores leave it unchanged.
// TESTING
//  SB addr 0x1003, wdata 0x12345678, ack 1st BUSY cycle -> bus_addr 0x1000, be 1000,
//   bus_wdata 0x78787878, bus_we 1, stall high 2 cycles, err 0.
//  LB addr 0x2002, bus_rdata 0x00800000 -> rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  LH addr 0x2001 -> no bus_req, stall 0, err pulse 1 cycle, rdata unchanged.
//  LW addr 0x3000, ack after 3 BUSY cycles, bus_rdata 0xDEADBEEF -> stall high 4 cycles,
//   rdata 0xDEADBEEF in DONE, be 1111.
//  TIMEOUT_CYCLES=4, no ack -> bus_req high exactly 4 cycles, err pulse, rdata 0, back to IDLE.
//  rst_n low during BUSY -> bus_req/stall drop asynchronously; after release, new SW proceeds normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one decoded load/store into a single word-aligned req/ack bus
// transaction with byte enables, extends load data, and stalls the core until it finishes.
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b011;
  localparam logic [2:0] MODE_HU = 3'b100;

  state_t        state;
  logic [TW-1:0] timer;
  logic          is_load;
  logic [2:0]    mode_q;
  logic [1:0]    off_q;

  logic          req;
  logic          illegal;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   lane;
  logic [31:0]   load_data;

  assign req = rd_en | wr_en;

  always_comb begin
    illegal = 1'b0;
    if (rd_en && wr_en) illegal = 1'b1;
    case (mem_acc_mode)
      MODE_B, MODE_BU: ;
      MODE_H, MODE_HU: if (addr[0]) illegal = 1'b1;
      MODE_W:          if (addr[1:0] != 2'b00) illegal = 1'b1;
      default:         illegal = 1'b1;
    endcase
    // Unsigned variants exist only for loads
    if (wr_en && (mem_acc_mode == MODE_BU || mem_acc_mode == MODE_HU)) illegal = 1'b1;
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (mem_acc_mode)
      MODE_B, MODE_BU: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      MODE_H, MODE_HU: begin
        be_next    = 4'b0011 << {addr[1], 1'b0};
        wdata_next = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane = bus_rdata >> {off_q, 3'b000};
    case (mode_q)
      MODE_B:  load_data = {{24{lane[7]}}, lane[7:0]};
      MODE_H:  load_data = {{16{lane[15]}}, lane[15:0]};
      MODE_BU: load_data = {24'd0, lane[7:0]};
      MODE_HU: load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Gated by rst_n so a reset during BUSY releases the pipeline immediately
  assign stall = rst_n && ((state == IDLE && req && !illegal) || state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      is_load   <= 1'b0;
      mode_q    <= 3'b000;
      off_q     <= 2'b00;
      rdata     <= 32'd0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'd0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= wr_en;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_next;
              bus_wdata <= wdata_next;
              is_load   <= rd_en;
              mode_q    <= mem_acc_mode;
              off_q     <= addr[1:0];
              timer     <= '0;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          // An ack arriving in the last allowed cycle still completes normally
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (is_load) rdata <= load_data;
            state   <= DONE;
          end else if (timer == TIMER_LAST) begin
            bus_req <= 1'b0;
            if (is_load) rdata <= 32'd0;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: transaction-level model of each load/store,
// per-cycle comparison of all outputs, plus directed cases with literal expectations.
module tb_lsu_mem_ctrl;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [2:0]  mem_acc_mode;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
    .mem_acc_mode(mem_acc_mode), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, filled in by the stimulus tasks
  logic        exp_stall, exp_err, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  bit          check_en = 1'b0;

  // Model state
  logic [31:0] m_rdata = 32'd0;

  // Observation counters and last-seen bus fields for directed literal checks
  int          stall_seen = 0, req_seen = 0, err_seen = 0;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_legal(bit rd, bit wr, logic [2:0] mode, logic [31:0] a);
    if (rd && wr) return 1'b0;
    if (mode > 3'd4) return 1'b0;
    if (wr && mode >= 3'd3) return 1'b0;
    if ((mode == 3'd1 || mode == 3'd4) && (a % 2) != 0) return 1'b0;
    if (mode == 3'd2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_size(logic [2:0] mode);
    if (mode == 3'd0 || mode == 3'd3) return 1;
    if (mode == 3'd1 || mode == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] mode, logic [31:0] a);
    int off = int'(a % 4);
    if (m_size(mode) == 1) return 4'(1 << off);
    if (m_size(mode) == 2) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] mode, logic [31:0] d);
    if (m_size(mode) == 1) return (d & 32'hFF) * 32'h01010101;
    if (m_size(mode) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ext(logic [2:0] mode, logic [31:0] a, logic [31:0] word);
    logic [31:0] v = word >> (8 * (a % 4));
    if (m_size(mode) == 1) begin
      v = v & 32'hFF;
      if (mode == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (m_size(mode) == 2) begin
      v = v & 32'hFFFF;
      if (mode == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Per-cycle comparison against the model expectations
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("stall", 32'(stall), 32'(exp_stall));
      checkOutput("err", 32'(err), 32'(exp_err));
      checkOutput("bus_req", 32'(bus_req), 32'(exp_req));
      checkOutput("rdata", rdata, exp_rdata);
      if (exp_req) begin
        checkOutput("bus_we", 32'(bus_we), 32'(exp_we));
        checkOutput("bus_addr", bus_addr, exp_addr);
        checkOutput("bus_be", 32'(bus_be), 32'(exp_be));
        checkOutput("bus_wdata", bus_wdata, exp_wdata);
      end
      if (stall) stall_seen++;
      if (bus_req) begin
        req_seen++;
        last_addr = bus_addr; last_be = bus_be; last_wdata = bus_wdata; last_we = bus_we;
      end
      if (err) err_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle(input logic err_now);
    rd_en = 1'b0; wr_en = 1'b0; bus_ack = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = err_now; exp_rdata = m_rdata;
  endtask

  // One core request; ack_at = BUSY cycle (1-based) carrying bus_ack, anything else never acks
  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] mode,
                               input logic [31:0] a, input logic [31:0] d,
                               input int ack_at, input logic [31:0] word);
    bit legal, done, timeout;
    rd_en = rd; wr_en = wr; mem_acc_mode = mode; addr = a; wdata = d; bus_ack = 1'b0;
    legal = m_legal(rd, wr, mode, a);
    exp_stall = (rd || wr) && legal;
    exp_req = 1'b0; exp_rdata = m_rdata;
    step();
    if (!(rd || wr)) begin setIdle(1'b0); return; end
    if (!legal) begin setIdle(1'b1); return; end
    exp_req = 1'b1; exp_stall = 1'b1; exp_err = 1'b0;
    exp_we = wr; exp_addr = a & 32'hFFFF_FFFC;
    exp_be = m_be(mode, a); exp_wdata = m_wdata(mode, d);
    timeout = 1'b0;
    for (int b = 1; b <= T; b++) begin
      bus_ack = (b == ack_at);
      bus_rdata = bus_ack ? word : $urandom;
      timeout = !bus_ack && (b == T);
      done = bus_ack || timeout;
      step();
      if (done) break;
    end
    bus_ack = 1'b0;
    if (rd) m_rdata = timeout ? 32'd0 : m_ext(mode, a, word);
    // DONE: inputs must be ignored, so scramble them
    rd_en = 1'($urandom); wr_en = 1'($urandom); mem_acc_mode = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    exp_req = 1'b0; exp_stall = 1'b0; exp_err = timeout; exp_rdata = m_rdata;
    step();
    setIdle(1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit rd, wr;
    logic [2:0] mode;
    int kind;
    rst_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; mem_acc_mode = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    #20;
    checkOutput("reset_bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_bus_be", 32'(bus_be), 32'd0);
    checkOutput("reset_bus_addr", bus_addr, 32'd0);
    checkOutput("reset_bus_wdata", bus_wdata, 32'd0);
    checkOutput("reset_bus_we", 32'(bus_we), 32'd0);
    #2 rst_n = 1'b1;
    step();
    setIdle(1'b0);
    check_en = 1'b1;

    // SB to the top byte lane
    stall_seen = 0;
    applyStimulus(1'b0, 1'b1, 3'd0, 32'h1003, 32'h12345678, 1, 32'd0);
    checkOutput("sb_stall_cycles", 32'(stall_seen), 32'd2);
    checkOutput("sb_addr", last_addr, 32'h1000);
    checkOutput("sb_be", 32'(last_be), 32'b1000);
    checkOutput("sb_wdata", last_wdata, 32'h78787878);
    checkOutput("sb_we", 32'(last_we), 32'd1);

    applyStimulus(1'b1, 1'b0, 3'd0, 32'h2002, 32'd0, 1, 32'h00800000);
    checkOutput("lb_rdata", rdata, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h2002, 32'd0, 1, 32'h00800000);
    checkOutput("lbu_rdata", rdata, 32'h00000080);

    // Misaligned LH: error pulse only
    req_seen = 0; stall_seen = 0; err_seen = 0;
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h2001, 32'd0, 1, 32'd0);
    step();
    setIdle(1'b0);
    step();
    checkOutput("lh_mis_req", 32'(req_seen), 32'd0);
    checkOutput("lh_mis_stall", 32'(stall_seen), 32'd0);
    checkOutput("lh_mis_err", 32'(err_seen), 32'd1);
    checkOutput("lh_mis_rdata", rdata, 32'h00000080);

    stall_seen = 0;
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h3000, 32'd0, 3, 32'hDEADBEEF);
    checkOutput("lw_stall_cycles", 32'(stall_seen), 32'd4);
    checkOutput("lw_rdata", rdata, 32'hDEADBEEF);
    checkOutput("lw_be", 32'(last_be), 32'hF);

    // Timeout with no ack
    req_seen = 0; err_seen = 0;
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h3004, 32'd0, 0, 32'd0);
    checkOutput("to_req_cycles", 32'(req_seen), 32'd4);
    checkOutput("to_err", 32'(err_seen), 32'd1);
    checkOutput("to_rdata", rdata, 32'd0);

    // Ack in the timeout cycle completes normally
    err_seen = 0;
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h3006, 32'd0, T, 32'h8001_0000);
    checkOutput("late_ack_err", 32'(err_seen), 32'd0);
    checkOutput("late_ack_rdata", rdata, 32'hFFFF8001);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      rd = (kind == 1) || (kind >= 2 && kind <= 5);
      wr = (kind == 1) || (kind >= 6);
      mode = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      applyStimulus(rd, wr, mode, $urandom, $urandom, $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        step();
        setIdle(1'b0);
      end
    end
    step();
    setIdle(1'b0);
    step();

    // Reset in the middle of BUSY
    check_en = 1'b0;
    rd_en = 1'b0; wr_en = 1'b1; mem_acc_mode = 3'd2; addr = 32'h80; wdata = 32'hA5A5A5A5;
    step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy_req", 32'(bus_req), 32'd0);
    checkOutput("rst_busy_stall", 32'(stall), 32'd0);
    rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    m_rdata = 32'd0;
    step();
    setIdle(1'b0);
    check_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 2, 32'd0);
    checkOutput("post_rst_addr", last_addr, 32'h40);
    checkOutput("post_rst_wdata", last_wdata, 32'hCAFEF00D);
    step();
    check_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
